dsp_scheduler: RTL

- Control FSM that sequences the shared multiply-accumulate (MAC) datapath of the audioport DSP filter, one sample frame at a time.
- On each sample tick it computes a TAPS-tap FIR result for the left channel, then for the right channel, on a single MAC.
- It emits coefficient/tap indices, MAC strobes, per-channel result write-enables and a completion tick.
- Sits in the clk domain between control_unit (tick, play, clr) and the DSP datapath; the completion tick drives dsp_tick.

---
 rtl/dsp_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dsp_scheduler.sv
// Frame sequencer for the shared audioport FIR MAC: one sample tick runs TAPS
// accumulations for the left channel, then TAPS for the right, then signals dsp_tick.
module dsp_scheduler #(
  parameter int TAPS  = 4,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             play_in,
  input  logic             clr_in,
  output logic             ch_sel_out,
  output logic [IDX_W-1:0] tap_idx_out,
  output logic             mac_clr_out,
  output logic             mac_en_out,
  output logic             result_we_out,
  output logic             shift_out,
  output logic             dsp_tick_out,
  output logic             busy_out,
  output logic             overrun_out
);

  typedef enum logic [2:0] {IDLE, CLR, MAC, WB, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

  state_t           state_q, state_d;
  logic             ch_q, ch_d;
  logic [IDX_W-1:0] tap_q, tap_d;
  logic             ovr_d;

  logic [IDX_W-1:0] tap_idx_q;
  logic             mac_clr_q, mac_en_q, result_we_q, done_q, busy_q, ovr_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tap_d   = tap_q;
    // A tick is only dropped while a frame is in flight; DONE can accept it.
    ovr_d   = tick_in && !clr_in && (state_q != IDLE) && (state_q != DONE);

    if (clr_in) begin
      state_d = IDLE;
      ch_d    = 1'b0;
      tap_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick_in && play_in) begin
            state_d = CLR;
            ch_d    = 1'b0;
          end
        end
        CLR: begin
          tap_d = '0;
          if (!play_in) begin
            state_d = IDLE;
            ch_d    = 1'b0;
          end else begin
            state_d = MAC;
          end
        end
        MAC: begin
          if (!play_in) begin
            state_d = IDLE;
            ch_d    = 1'b0;
            tap_d   = '0;
          end else if (tap_q == LAST_TAP) begin
            state_d = WB;
            tap_d   = '0;
          end else begin
            tap_d = tap_q + IDX_W'(1);
          end
        end
        WB: begin
          if (!play_in) begin
            state_d = IDLE;
            ch_d    = 1'b0;
          end else if (!ch_q) begin
            state_d = CLR;
            ch_d    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          ch_d    = 1'b0;
          state_d = (tick_in && play_in) ? CLR : IDLE;
        end
        default: begin
          state_d = IDLE;
          ch_d    = 1'b0;
          tap_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= 1'b0;
      tap_q       <= '0;
      tap_idx_q   <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      result_we_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      tap_q       <= tap_d;
      tap_idx_q   <= (state_d == MAC) ? tap_d : '0;
      mac_clr_q   <= (state_d == CLR);
      mac_en_q    <= (state_d == MAC);
      result_we_q <= (state_d == WB);
      done_q      <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      ovr_q       <= ovr_d;
    end
  end

  assign ch_sel_out    = ch_q;
  assign tap_idx_out   = tap_idx_q;
  assign mac_clr_out   = mac_clr_q;
  assign mac_en_out    = mac_en_q;
  assign result_we_out = result_we_q;
  assign shift_out     = done_q;
  assign dsp_tick_out  = done_q;
  assign busy_out      = busy_q;
  assign overrun_out   = ovr_q;

endmodule
